// File: rtl/activation_scheduler_pkg.sv
// Shared types and helpers for the activation scheduler.
// Optional build macro: ACTIVATION_SCHEDULER_PERF_EN (performance counters).
package activation_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PERF_W = 32;

    function automatic int beats(input int nodes, input int lanes);
        return nodes / lanes;
    endfunction

endpackage

// File: rtl/activation_scheduler_tagpipe.sv
// Delay line matching the activation lane latency; its output marks the
// cycle in which act_out carries the result of an issued beat.
module activation_scheduler_tagpipe #(
    parameter int ACT_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic act_en,
    output logic tag
);

    logic [ACT_LATENCY-1:0] pipe_r;

    // Shift the issue strobe one stage per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= act_en;
            for (int i = 1; i < ACT_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag = pipe_r[ACT_LATENCY-1];

endmodule

// File: rtl/activation_scheduler.sv
// Streams one FC output vector through the activation lanes beat by beat
// and reassembles the results. Optional macro: ACTIVATION_SCHEDULER_PERF_EN.
module activation_scheduler
    import activation_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OUTPUT_NODES = 32,
    parameter int LANES        = 8,
    parameter int ACT_LATENCY  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] in_vec,
    output logic                               act_en,
    output logic [DATA_WIDTH*LANES-1:0]        act_in,
    input  logic [DATA_WIDTH*LANES-1:0]        act_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_vec,
    output logic                               busy
`ifdef ACTIVATION_SCHEDULER_PERF_EN
    ,
    output logic [PERF_W-1:0]                  perf_jobs,
    output logic [PERF_W-1:0]                  perf_stall
`endif
);

    localparam int BEATS  = beats(OUTPUT_NODES, LANES);
    localparam int CW     = $clog2(BEATS + 1);
    localparam int BEAT_W = DATA_WIDTH * LANES;
    localparam int VEC_W  = DATA_WIDTH * OUTPUT_NODES;

    state_t            state_r;
    state_t            state_s;
    logic [VEC_W-1:0]  in_buf_r;
    logic [VEC_W-1:0]  out_buf_r;
    logic [CW-1:0]     issue_idx_r;
    logic [CW-1:0]     cap_idx_r;
    logic              tag_s;
    logic              accept_s;
    logic              last_issue_s;
    logic              last_cap_s;

    assign accept_s     = (state_r == IDLE) && in_valid;
    assign last_issue_s = (issue_idx_r == CW'(BEATS - 1));
    assign last_cap_s   = tag_s && (cap_idx_r == CW'(BEATS - 1));

    activation_scheduler_tagpipe #(
        .ACT_LATENCY(ACT_LATENCY)
    ) u_tagpipe (
        .clk   (clk),
        .reset (reset),
        .act_en(act_en),
        .tag   (tag_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; completion is only observed in DRAIN because the
    // last capture always trails the last issue by at least one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (last_issue_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (last_cap_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Input latch and beat issue index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf_r    <= '0;
            issue_idx_r <= '0;
        end else if (accept_s) begin
            in_buf_r    <= in_vec;
            issue_idx_r <= '0;
        end else if (state_r == ISSUE) begin
            issue_idx_r <= issue_idx_r + CW'(1);
        end
    end

    // Result capture on tag strobes, in ISSUE and DRAIN alike
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf_r <= '0;
            cap_idx_r <= '0;
        end else if (accept_s) begin
            cap_idx_r <= '0;
        end else if (tag_s) begin
            out_buf_r[int'(cap_idx_r)*BEAT_W +: BEAT_W] <= act_out;
            cap_idx_r <= cap_idx_r + CW'(1);
        end
    end

    // Beat presented to the lanes
    always_comb begin
        act_in = '0;
        if (state_r == ISSUE) begin
            act_in = in_buf_r[int'(issue_idx_r)*BEAT_W +: BEAT_W];
        end else begin
            act_in = '0;
        end
    end

    assign in_ready  = (state_r == IDLE) && reset;
    assign act_en    = (state_r == ISSUE);
    assign out_valid = (state_r == DONE);
    assign out_vec   = out_buf_r;
    assign busy      = (state_r != IDLE);

`ifdef ACTIVATION_SCHEDULER_PERF_EN
    logic [PERF_W-1:0] perf_jobs_r;
    logic [PERF_W-1:0] perf_stall_r;

    // Saturating handshake and stall counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_jobs_r  <= '0;
            perf_stall_r <= '0;
        end else begin
            if (out_valid && out_ready && (perf_jobs_r != '1)) begin
                perf_jobs_r <= perf_jobs_r + PERF_W'(1);
            end
            if (out_valid && !out_ready && (perf_stall_r != '1)) begin
                perf_stall_r <= perf_stall_r + PERF_W'(1);
            end
        end
    end

    assign perf_jobs  = perf_jobs_r;
    assign perf_stall = perf_stall_r;
`else
    // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler: default configuration plus a
// single-beat, three-cycle-latency instance; lanes modelled as ReLU.
module tb_activation_scheduler;

    logic          clk;
    logic          reset;
    logic          in_valid, in_ready, act_en, out_valid, out_ready, busy;
    logic [1023:0] in_vec, out_vec;
    logic [255:0]  act_in, act_out;
    logic          in_valid2, in_ready2, act_en2, out_valid2, out_ready2, busy2;
    logic [1023:0] in_vec2, out_vec2, act_in2, act_out2;
`ifdef ACTIVATION_SCHEDULER_PERF_EN
    logic [31:0]   perf_jobs, perf_stall, perf_jobs2, perf_stall2;
`endif

    int vectors = 0;
    int miscompares = 0;

    activation_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .act_en(act_en), .act_in(act_in), .act_out(act_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
`ifdef ACTIVATION_SCHEDULER_PERF_EN
        , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
    );

    activation_scheduler #(.DATA_WIDTH(32), .OUTPUT_NODES(32), .LANES(32), .ACT_LATENCY(3)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_vec(in_vec2), .act_en(act_en2), .act_in(act_in2), .act_out(act_out2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_vec(out_vec2), .busy(busy2)
`ifdef ACTIVATION_SCHEDULER_PERF_EN
        , .perf_jobs(perf_jobs2), .perf_stall(perf_stall2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1023:0] relu(input logic [1023:0] v);
        logic [1023:0] r;
        for (int w = 0; w < 32; w++) begin
            r[w*32 +: 32] = v[w*32 + 31] ? 32'h0000_0000 : v[w*32 +: 32];
        end
        return r;
    endfunction

    // Lane models: latency 1 for dut, latency 3 for dut2
    logic [1023:0] relu1_s;
    logic [1023:0] d2_r [3];
    assign relu1_s  = relu({768'd0, act_in});
    assign act_out2 = d2_r[2];
    always @(posedge clk) begin
        act_out <= relu1_s[255:0];
        d2_r[0] <= relu(act_in2);
        d2_r[1] <= d2_r[0];
        d2_r[2] <= d2_r[1];
    end

    task automatic do_reset;
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_vec2 = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_vec2 = '0;
        #1 reset = 1'b0;
        #2;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++; if (act_en !== 1'b0) begin miscompares++; $display("FAIL rst_act_en got %b want 0", act_en); end
        vectors++; if (act_in !== 256'd0) begin miscompares++; $display("FAIL rst_act_in got %h want 0", act_in); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++; if (out_vec !== 1024'd0) begin miscompares++; $display("FAIL rst_out_vec low word got %h want 0", out_vec[31:0]); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_relu_neg;
        logic [1023:0] v;
        logic ea, eb, ev, er, bad;
        v = {32{32'h8000_0000}};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            in_valid = (c == 0);
            in_vec = v;
            @(negedge clk);
            ea = (c >= 1 && c <= 4); eb = (c >= 1 && c <= 6);
            ev = (c == 6); er = (c == 0 || c >= 7);
            vectors++; if (act_en !== ea) begin miscompares++; $display("FAIL neg_act_en cycle %0d got %b want %b", c, act_en, ea); end
            vectors++; if (busy !== eb) begin miscompares++; $display("FAIL neg_busy cycle %0d got %b want %b", c, busy, eb); end
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL neg_out_valid cycle %0d got %b want %b", c, out_valid, ev); end
            vectors++; if (in_ready !== er) begin miscompares++; $display("FAIL neg_in_ready cycle %0d got %b want %b", c, in_ready, er); end
            if (ea) begin
                vectors++; if (act_in !== v[(c-1)*256 +: 256]) begin miscompares++; $display("FAIL neg_act_in cycle %0d got %h want %h", c, act_in, v[(c-1)*256 +: 256]); end
            end
            if (c == 6) begin
                vectors++; bad = 1'b0;
                for (int w = 0; w < 32; w++) begin
                    if (out_vec[w*32 +: 32] !== 32'h0000_0000) begin bad = 1'b1; $display("FAIL neg_out_vec word %0d got %h want 00000000", w, out_vec[w*32 +: 32]); end
                end
                if (bad) miscompares++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mixed;
        logic [1023:0] v, e;
        logic bad;
        v = {32{32'h4000_0000}};
        v[30*32 +: 32] = 32'h8000_0000;
        e = {32{32'h4000_0000}};
        e[30*32 +: 32] = 32'h0000_0000;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            in_valid = (c == 0);
            in_vec = v;
            @(negedge clk);
            if (c == 4) begin
                vectors++; if (act_in !== v[1023:768]) begin miscompares++; $display("FAIL mix_beat3 got %h want %h", act_in, v[1023:768]); end
            end
            if (c == 6) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mix_out_valid got %b want 1", out_valid); end
                vectors++; bad = 1'b0;
                for (int w = 0; w < 32; w++) begin
                    if (out_vec[w*32 +: 32] !== e[w*32 +: 32]) begin bad = 1'b1; $display("FAIL mix_out_vec word %0d got %h want %h", w, out_vec[w*32 +: 32], e[w*32 +: 32]); end
                end
                if (bad) miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [1023:0] v, e;
        logic ev, er, eb, bad;
        for (int k = 0; k < 32; k++) begin
            v[k*32 +: 32] = k[0] ? (32'h8000_0000 | 32'(k)) : (32'h3F80_0000 + 32'(k));
            e[k*32 +: 32] = k[0] ? 32'h0000_0000 : (32'h3F80_0000 + 32'(k));
        end
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            in_vec = (c == 0) ? v : ~v;
            in_valid = (c == 0 || c == 7 || c == 9);
            out_ready = (c == 11);
            @(negedge clk);
            ev = (c >= 6 && c <= 11); er = (c == 0 || c >= 12); eb = (c >= 1 && c <= 11);
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL bp_out_valid cycle %0d got %b want %b", c, out_valid, ev); end
            vectors++; if (in_ready !== er) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, er); end
            vectors++; if (busy !== eb) begin miscompares++; $display("FAIL bp_busy cycle %0d got %b want %b", c, busy, eb); end
            if (c >= 6) begin
                vectors++; bad = 1'b0;
                for (int w = 0; w < 32; w++) begin
                    if (out_vec[w*32 +: 32] !== e[w*32 +: 32]) begin bad = 1'b1; $display("FAIL bp_out_vec cycle %0d word %0d got %h want %h", c, w, out_vec[w*32 +: 32], e[w*32 +: 32]); end
                end
                if (bad) miscompares++;
            end
`ifdef ACTIVATION_SCHEDULER_PERF_EN
            if (c == 12) begin
                vectors++; if (perf_jobs !== 32'd1) begin miscompares++; $display("FAIL bp_perf_jobs got %0d want 1", perf_jobs); end
                vectors++; if (perf_stall !== 32'd5) begin miscompares++; $display("FAIL bp_perf_stall got %0d want 5", perf_stall); end
            end
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_midjob_reset;
        logic [1023:0] v, e;
        logic ev, bad;
        v = {32{32'h3F80_0000}};
        do_reset();
        out_ready = 1'b1;
        in_vec = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        vectors++; if ({in_ready, act_en, out_valid, busy} !== 4'b0000) begin miscompares++; $display("FAIL mr_ctrl got %b want 0000", {in_ready, act_en, out_valid, busy}); end
        vectors++; if (act_in !== 256'd0) begin miscompares++; $display("FAIL mr_act_in got %h want 0", act_in); end
        vectors++; if (out_vec !== 1024'd0) begin miscompares++; $display("FAIL mr_out_vec nonzero, low word %h want 0", out_vec[31:0]); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            vectors++; if ({in_ready, out_valid, busy} !== 3'b100) begin miscompares++; $display("FAIL mr_after cycle %0d got %b want 100", c, {in_ready, out_valid, busy}); end
            vectors++; if (out_vec !== 1024'd0) begin miscompares++; $display("FAIL mr_after_out_vec cycle %0d low word %h want 0", c, out_vec[31:0]); end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 32; k++) begin
            v[k*32 +: 32] = (k < 16) ? 32'hC120_0000 : 32'h4120_0000;
            e[k*32 +: 32] = (k < 16) ? 32'h0000_0000 : 32'h4120_0000;
        end
        for (int c = 0; c <= 7; c++) begin
            in_valid = (c == 0);
            in_vec = v;
            @(negedge clk);
            ev = (c == 6);
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL mr_new_out_valid cycle %0d got %b want %b", c, out_valid, ev); end
            if (c == 6) begin
                vectors++; bad = 1'b0;
                for (int w = 0; w < 32; w++) begin
                    if (out_vec[w*32 +: 32] !== e[w*32 +: 32]) begin bad = 1'b1; $display("FAIL mr_new_out_vec word %0d got %h want %h", w, out_vec[w*32 +: 32], e[w*32 +: 32]); end
                end
                if (bad) miscompares++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [1023:0] v1, v2;
        logic ev, er;
        v1 = {32{32'h3F80_0000}};
        v2 = {32{32'hBF80_0000}};
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            in_vec = (c <= 6) ? v1 : v2;
            @(negedge clk);
            ev = (c == 6 || c == 13); er = (c == 0 || c == 7 || c == 14);
            vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL b2b_out_valid cycle %0d got %b want %b", c, out_valid, ev); end
            vectors++; if (in_ready !== er) begin miscompares++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, in_ready, er); end
            if (c == 6) begin
                vectors++; if (out_vec !== v1) begin miscompares++; $display("FAIL b2b_job1 low word got %h want 3f800000", out_vec[31:0]); end
            end
            if (c == 13) begin
                vectors++; if (out_vec !== 1024'd0) begin miscompares++; $display("FAIL b2b_job2 low word got %h want 00000000", out_vec[31:0]); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_lat3;
        logic [1023:0] v, e;
        logic ea, ev, eb, bad;
        for (int k = 0; k < 32; k++) begin
            v[k*32 +: 32] = k[0] ? 32'hC000_0000 : 32'h4040_0000;
            e[k*32 +: 32] = k[0] ? 32'h0000_0000 : 32'h4040_0000;
        end
        do_reset();
        out_ready2 = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            in_valid2 = (c == 0);
            in_vec2 = v;
            @(negedge clk);
            ea = (c == 1); ev = (c == 5); eb = (c >= 1 && c <= 5);
            vectors++; if (act_en2 !== ea) begin miscompares++; $display("FAIL l3_act_en cycle %0d got %b want %b", c, act_en2, ea); end
            vectors++; if (out_valid2 !== ev) begin miscompares++; $display("FAIL l3_out_valid cycle %0d got %b want %b", c, out_valid2, ev); end
            vectors++; if (busy2 !== eb) begin miscompares++; $display("FAIL l3_busy cycle %0d got %b want %b", c, busy2, eb); end
            if (c == 5) begin
                vectors++; bad = 1'b0;
                for (int w = 0; w < 32; w++) begin
                    if (out_vec2[w*32 +: 32] !== e[w*32 +: 32]) begin bad = 1'b1; $display("FAIL l3_out_vec word %0d got %h want %h", w, out_vec2[w*32 +: 32], e[w*32 +: 32]); end
                end
                if (bad) miscompares++;
            end
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_relu_neg();
        test_mixed();
        test_backpressure();
        test_midjob_reset();
        test_back_to_back();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
